// File: rtl/revisar_celda_pkg.sv
`default_nettype none
// ============================================================================
// Module      : revisar_celda_pkg
// Description : FSM states, neighbour offset table and bomb encoding shared by
//               the cell-reveal logic.
// Revision    : 1.0 - initial release
// ============================================================================
package revisar_celda_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CENTRO  = 3'd1,
        EVAL    = 3'd2,
        VECINOS = 3'd3,
        ULTIMO  = 3'd4,
        RESP    = 3'd5
    } estado_t;

    // Sign-extended by the size cast at the point of use, so any CELDA_W works.
    localparam int BOMBA = -1;

    // Scan order: upper row left to right, middle row, lower row.
    localparam int DX [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    localparam int DY [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};

endpackage
`default_nettype wire

// File: rtl/revisar_celda_mapa.sv
`default_nettype none
// ============================================================================
// Module      : mapa_revelado
// Description : Revealed-cell bitmap plus counter; raises a sticky victoria
//               once OBJETIVO distinct cells have been marked.
// Revision    : 1.0 - initial release
// ============================================================================
module mapa_revelado #(
    parameter int CELDAS   = 64,
    parameter int OBJETIVO = 54
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      marcar,
    input  logic [$clog2(CELDAS)-1:0] celda,
    output logic                      revelada,
    output logic                      victoria
);

    localparam int CW = $clog2(CELDAS + 1);

    logic [CELDAS-1:0] r_mapa;
    logic [CW-1:0]     r_cuenta;
    logic              r_victoria;

    assign revelada = r_mapa[celda];
    assign victoria = r_victoria;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mapa     <= '0;
            r_cuenta   <= '0;
            r_victoria <= 1'b0;
        end else if (marcar && !r_mapa[celda]) begin
            r_mapa[celda] <= 1'b1;
            r_cuenta      <= r_cuenta + CW'(1);
            if (int'(r_cuenta) + 1 == OBJETIVO) begin
                r_victoria <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/revisar_celda.sv
`default_nettype none
// ============================================================================
// Module      : revisar_celda
// Description : Minesweeper cell reveal: reads the centre cell, then scans the
//               8 neighbours and reports bomb / adjacent-bomb count.
//               Optional macro REVISAR_CELDA_VICTORIA_EN adds the revealed map
//               and win detection.
// Revision    : 1.0 - initial release
// ============================================================================
module revisar_celda
    import revisar_celda_pkg::*;
#(
    parameter int FILAS      = 8,
    parameter int COLUMNAS   = 8,
    parameter int CELDA_W    = 8,
    parameter int NUM_BOMBAS = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [$clog2(COLUMNAS)-1:0]          req_x,
    input  logic [$clog2(FILAS)-1:0]             req_y,
    output logic                                 mem_rd_en,
    output logic [$clog2(FILAS*COLUMNAS)-1:0]    mem_addr,
    input  logic [CELDA_W-1:0]                   mem_data,
    output logic                                 resp_valid,
    input  logic                                 resp_ready,
    output logic                                 resp_bomba,
    output logic [3:0]                           resp_vecinos,
    output logic                                 resp_error,
    output logic                                 resp_repetida,
    output logic                                 game_over,
    output logic                                 victoria
);

    localparam int XW = $clog2(COLUMNAS);
    localparam int YW = $clog2(FILAS);
    localparam int AW = $clog2(FILAS * COLUMNAS);

    estado_t       r_estado;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [2:0]    r_idx;
    logic [3:0]    r_cnt;
    logic          r_rd_prev;
    logic          r_req_ready;
    logic          r_mem_rd_en;
    logic [AW-1:0] r_mem_addr;
    logic          r_resp_valid;
    logic          r_resp_bomba;
    logic [3:0]    r_resp_vecinos;
    logic          r_resp_error;
    logic          r_resp_repetida;
    logic          r_game_over;

    logic          w_es_bomba;
    logic          w_inc;
    logic          w_fuera;
    logic [AW-1:0] w_centro_req;
    logic [2:0]    w_nb_sel;
    int            w_nx;
    int            w_ny;
    logic          w_nb_ok;
    logic [AW-1:0] w_nb_addr;
    logic          w_revelada;
    logic          w_victoria;

    assign w_es_bomba   = (mem_data == CELDA_W'(BOMBA));
    // Only count data that answers a read actually issued last cycle.
    assign w_inc        = r_rd_prev && w_es_bomba;
    assign w_fuera      = (int'(req_x) >= COLUMNAS) || (int'(req_y) >= FILAS);
    assign w_centro_req = AW'(int'(req_y) * COLUMNAS + int'(req_x));

    // Neighbour to issue at the coming edge: index 0 from EVAL, idx+1 in the scan.
    always_comb begin
        w_nb_sel  = (r_estado == VECINOS) ? (r_idx + 3'd1) : 3'd0;
        w_nx      = int'(r_x) + DX[w_nb_sel];
        w_ny      = int'(r_y) + DY[w_nb_sel];
        w_nb_ok   = (w_nx >= 0) && (w_nx < COLUMNAS) && (w_ny >= 0) && (w_ny < FILAS);
        w_nb_addr = AW'(w_ny * COLUMNAS + w_nx);
    end

`ifdef REVISAR_CELDA_VICTORIA_EN
    logic [AW-1:0] w_centro;
    logic          w_marcar;

    assign w_centro = AW'(int'(r_y) * COLUMNAS + int'(r_x));
    assign w_marcar = (r_estado == ULTIMO) && !w_revelada;

    mapa_revelado #(
        .CELDAS   (FILAS * COLUMNAS),
        .OBJETIVO (FILAS * COLUMNAS - NUM_BOMBAS)
    ) u_mapa (
        .clk      (clk),
        .rst      (rst),
        .marcar   (w_marcar),
        .celda    (w_centro),
        .revelada (w_revelada),
        .victoria (w_victoria)
    );
`else
    assign w_revelada = 1'b0;
    assign w_victoria = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado        <= IDLE;
            r_x             <= '0;
            r_y             <= '0;
            r_idx           <= '0;
            r_cnt           <= '0;
            r_rd_prev       <= 1'b0;
            r_req_ready     <= 1'b1;
            r_mem_rd_en     <= 1'b0;
            r_mem_addr      <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_bomba    <= 1'b0;
            r_resp_vecinos  <= '0;
            r_resp_error    <= 1'b0;
            r_resp_repetida <= 1'b0;
            r_game_over     <= 1'b0;
        end else begin
            r_rd_prev <= r_mem_rd_en;
            case (r_estado)
                IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_x         <= req_x;
                        r_y         <= req_y;
                        r_cnt       <= '0;
                        if (w_fuera) begin
                            r_estado        <= RESP;
                            r_resp_valid    <= 1'b1;
                            r_resp_error    <= 1'b1;
                            r_resp_bomba    <= 1'b0;
                            r_resp_vecinos  <= '0;
                            r_resp_repetida <= 1'b0;
                        end else begin
                            r_estado    <= CENTRO;
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= w_centro_req;
                        end
                    end
                end
                CENTRO: begin
                    r_mem_rd_en <= 1'b0;
                    r_estado    <= EVAL;
                end
                EVAL: begin
                    if (w_es_bomba) begin
                        r_estado        <= RESP;
                        r_resp_valid    <= 1'b1;
                        r_resp_bomba    <= 1'b1;
                        r_resp_vecinos  <= '0;
                        r_resp_error    <= 1'b0;
                        r_resp_repetida <= 1'b0;
                        r_game_over     <= 1'b1;
                    end else begin
                        r_estado    <= VECINOS;
                        r_idx       <= '0;
                        r_mem_rd_en <= w_nb_ok;
                        if (w_nb_ok) begin
                            r_mem_addr <= w_nb_addr;
                        end
                    end
                end
                VECINOS: begin
                    r_cnt <= r_cnt + {3'd0, w_inc};
                    if (r_idx == 3'd7) begin
                        r_estado    <= ULTIMO;
                        r_mem_rd_en <= 1'b0;
                    end else begin
                        r_idx       <= r_idx + 3'd1;
                        r_mem_rd_en <= w_nb_ok;
                        if (w_nb_ok) begin
                            r_mem_addr <= w_nb_addr;
                        end
                    end
                end
                ULTIMO: begin
                    r_estado        <= RESP;
                    r_resp_valid    <= 1'b1;
                    r_resp_bomba    <= 1'b0;
                    r_resp_vecinos  <= r_cnt + {3'd0, w_inc};
                    r_resp_error    <= 1'b0;
                    r_resp_repetida <= w_revelada;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_estado     <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= !r_game_over && !w_victoria;
                    end
                end
                default: begin
                    r_estado    <= IDLE;
                    r_mem_rd_en <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign mem_rd_en     = r_mem_rd_en;
    assign mem_addr      = r_mem_addr;
    assign resp_valid    = r_resp_valid;
    assign resp_bomba    = r_resp_bomba;
    assign resp_vecinos  = r_resp_vecinos;
    assign resp_error    = r_resp_error;
    assign resp_repetida = r_resp_repetida;
    assign game_over     = r_game_over;
    assign victoria      = w_victoria;

endmodule
`default_nettype wire

// File: tb/tb_revisar_celda.sv
`default_nettype none
// ============================================================================
// Module      : tb_revisar_celda
// Description : Directed self-checking bench: 8x8 board, 2x2 win board and a
//               6x5 board for out-of-range coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_revisar_celda;

`ifdef REVISAR_CELDA_VICTORIA_EN
    localparam int VIC = 1;
`else
    localparam int VIC = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]      rx = '0;
    logic [2:0]      ry = '0;
    logic            rr = 1'b1;
    logic [2:0]      vld = '0;
    logic [2:0]      rdy, rd, rv, bom, err, rep, go, vic;
    logic [2:0][3:0] vec;
    logic [2:0][5:0] addr;
    logic [2:0][7:0] mdat = '0;
    logic [5:0]      addr_a;
    logic [1:0]      addr_b;
    logic [4:0]      addr_c;
    logic [7:0]      brd [3][64];

    assign addr[0] = addr_a;
    assign addr[1] = {4'd0, addr_b};
    assign addr[2] = {1'b0, addr_c};

    revisar_celda #(.FILAS(8), .COLUMNAS(8), .CELDA_W(8), .NUM_BOMBAS(3)) dut_a (
        .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_x(rx), .req_y(ry), .mem_rd_en(rd[0]), .mem_addr(addr_a),
        .mem_data(mdat[0]), .resp_valid(rv[0]), .resp_ready(rr),
        .resp_bomba(bom[0]), .resp_vecinos(vec[0]), .resp_error(err[0]),
        .resp_repetida(rep[0]), .game_over(go[0]), .victoria(vic[0]));

    revisar_celda #(.FILAS(2), .COLUMNAS(2), .CELDA_W(8), .NUM_BOMBAS(1)) dut_b (
        .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_x(rx[0:0]), .req_y(ry[0:0]), .mem_rd_en(rd[1]), .mem_addr(addr_b),
        .mem_data(mdat[1]), .resp_valid(rv[1]), .resp_ready(rr),
        .resp_bomba(bom[1]), .resp_vecinos(vec[1]), .resp_error(err[1]),
        .resp_repetida(rep[1]), .game_over(go[1]), .victoria(vic[1]));

    // 3-bit coordinates on a 6x5 board can name cells outside it
    revisar_celda #(.FILAS(5), .COLUMNAS(6), .CELDA_W(8), .NUM_BOMBAS(2)) dut_c (
        .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy[2]),
        .req_x(rx), .req_y(ry), .mem_rd_en(rd[2]), .mem_addr(addr_c),
        .mem_data(mdat[2]), .resp_valid(rv[2]), .resp_ready(rr),
        .resp_bomba(bom[2]), .resp_vecinos(vec[2]), .resp_error(err[2]),
        .resp_repetida(rep[2]), .game_over(go[2]), .victoria(vic[2]));

    // Board memory: one-cycle read latency, all-ones garbage when not reading
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            mdat[d] <= rd[d] ? brd[d][addr[d]] : 8'hFF;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    int n_rd, t_resp;
    int rd_addr [16];
    int rd_cyc [16];
    int c_bom, c_vec, c_err, c_rep, c_vic, c_go;

    // Issue one request on DUT d; cycle k after acceptance is sampled at the k-th negedge.
    task automatic peticion(input int d, input int x, input int y, input int max_c);
        n_rd   = 0;
        t_resp = -1;
        @(negedge clk);
        check("acepta", int'(rdy[d]), 1);
        rx     = 3'(x);
        ry     = 3'(y);
        vld[d] = 1'b1;
        @(posedge clk);
        #1 vld[d] = 1'b0;
        for (int k = 1; k <= max_c && t_resp < 0; k++) begin
            @(negedge clk);
            if (rd[d] && n_rd < 16) begin
                rd_addr[n_rd] = int'(addr[d]);
                rd_cyc[n_rd]  = k;
                n_rd++;
            end
            if (rv[d]) begin
                t_resp = k;
                c_bom  = int'(bom[d]);
                c_vec  = int'(vec[d]);
                c_err  = int'(err[d]);
                c_rep  = int'(rep[d]);
                c_vic  = int'(vic[d]);
                c_go   = int'(go[d]);
            end
        end
    endtask

    initial begin
        int ea [4];
        int ec [4];
        int estable, cuenta;

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 64; i++) begin
                brd[d][i] = 8'(i);
            end
        end
        brd[0][1]  = 8'hFF;
        brd[0][9]  = 8'hFF;
        brd[0][27] = 8'hFF;
        brd[1][3]  = 8'hFF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", int'(rdy[0]), 1);
        check("rst_rd_en", int'(rd[0]), 0);
        check("rst_addr", int'(addr[0]), 0);
        check("rst_valid", int'(rv[0]), 0);
        check("rst_vecinos", int'(vec[0]), 0);
        check("rst_game_over", int'(go[0]), 0);
        check("rst_victoria", int'(vic[0]), 0);

        // Corner (0,0): bombs at (1,0) and (1,1)
        peticion(0, 0, 0, 16);
        check("esq_t_resp", t_resp, 12);
        check("esq_vecinos", c_vec, 2);
        check("esq_bomba", c_bom, 0);
        check("esq_error", c_err, 0);
        check("esq_n_lect", n_rd, 4);
        ea = '{0, 1, 8, 9};
        ec = '{1, 7, 9, 10};
        for (int i = 0; i < 4; i++) begin
            if (i < n_rd) begin
                check("esq_dir", rd_addr[i], ea[i]);
                check("esq_ciclo", rd_cyc[i], ec[i]);
            end
        end
        @(negedge clk);
        check("esq_idle_ready", int'(rdy[0]), 1);
        check("esq_idle_valid", int'(rv[0]), 0);

        // (2,4) next to bomb (3,3), consumer stalls 5 cycles
        rr = 1'b0;
        peticion(0, 2, 4, 16);
        check("stall_t_resp", t_resp, 12);
        check("stall_vecinos", c_vec, 1);
        estable = 1;
        repeat (5) begin
            @(negedge clk);
            if (!(rv[0] && vec[0] == 4'd1 && !bom[0] && !err[0] && !rdy[0] && !rd[0]))
                estable = 0;
        end
        check("stall_estable", estable, 1);
        rr = 1'b1;
        @(negedge clk);
        check("stall_idle_ready", int'(rdy[0]), 1);
        check("stall_idle_valid", int'(rv[0]), 0);

        // Reset during the neighbour scan
        @(negedge clk);
        rx     = 3'd4;
        ry     = 3'd4;
        vld[0] = 1'b1;
        @(posedge clk);
        #1 vld[0] = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready", int'(rdy[0]), 1);
        check("mid_rst_rd_en", int'(rd[0]), 0);
        check("mid_rst_addr", int'(addr[0]), 0);
        check("mid_rst_valid", int'(rv[0]), 0);
        check("mid_rst_vecinos", int'(vec[0]), 0);

        // Corner (7,7): no adjacent bombs, reads 54, 55, 62
        peticion(0, 7, 7, 16);
        check("e77_t_resp", t_resp, 12);
        check("e77_vecinos", c_vec, 0);
        check("e77_n_lect", n_rd, 4);
        if (n_rd == 4) begin
            check("e77_dir3", rd_addr[3], 62);
            check("e77_ciclo3", rd_cyc[3], 6);
        end

        // Out of range on the 6x5 board
        peticion(2, 7, 0, 4);
        check("err_x_t_resp", t_resp, 1);
        check("err_x_error", c_err, 1);
        check("err_x_n_lect", n_rd, 0);
        peticion(2, 0, 5, 4);
        check("err_y_t_resp", t_resp, 1);
        check("err_y_error", c_err, 1);
        check("err_y_n_lect", n_rd, 0);

        // Bomb at the centre (3,3)
        peticion(0, 3, 3, 16);
        check("bomba_t_resp", t_resp, 3);
        check("bomba_bomba", c_bom, 1);
        check("bomba_vecinos", c_vec, 0);
        check("bomba_game_over", c_go, 1);
        check("bomba_n_lect", n_rd, 1);
        @(negedge clk);
        vld[0] = 1'b1;
        cuenta = 0;
        repeat (4) begin
            @(negedge clk);
            if (rdy[0] || rd[0] || rv[0]) cuenta++;
        end
        vld[0] = 1'b0;
        check("bomba_bloqueo", cuenta, 0);
        check("bomba_sticky", int'(go[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("bomba_rst_go", int'(go[0]), 0);
        check("bomba_rst_ready", int'(rdy[0]), 1);

        // 2x2 board, bomb at (1,1): three safe cells, (0,0) twice
        peticion(1, 0, 0, 16);
        check("v1_vecinos", c_vec, 1);
        check("v1_repetida", c_rep, 0);
        check("v1_victoria", c_vic, 0);
        peticion(1, 0, 0, 16);
        check("v2_repetida", c_rep, VIC);
        check("v2_victoria", c_vic, 0);
        peticion(1, 1, 0, 16);
        check("v3_vecinos", c_vec, 1);
        check("v3_victoria", c_vic, 0);
        peticion(1, 0, 1, 16);
        check("v4_t_resp", t_resp, 12);
        check("v4_repetida", c_rep, 0);
        check("v4_victoria", c_vic, VIC);
        @(negedge clk);
        check("v4_ready", int'(rdy[1]), 1 - VIC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
